// File: rtl/sdp_rdma_layer_ctrl_if.sv
// Read-request / credit interface between the SDP layer read-DMA controller
// and the memory interface fabric.
//
// Signals:
//   rd_req_valid  one-hot request valid, one bit per memory interface
//   rd_req_ready  per-interface ready
//   rd_req_pd     request payload {size, addr}, shared by all interfaces
//   rd_cdt_pop    one atom popped from the latency FIFO by the egress
//
// Modports:
//   master  the DMA controller (drives valid/pd, observes ready/pop)
//   slave   the memory side (drives ready/pop, observes valid/pd)
interface sdp_rdma_layer_ctrl_if #(
    parameter int unsigned AW     = 64,
    parameter int unsigned NUM_IF = 2,
    parameter int unsigned SZ_W   = 15
) ();
    logic [NUM_IF-1:0]    rd_req_valid;
    logic [NUM_IF-1:0]    rd_req_ready;
    logic [AW+SZ_W-1:0]   rd_req_pd;
    logic                 rd_cdt_pop;

    modport master (
        output rd_req_valid,
        output rd_req_pd,
        input  rd_req_ready,
        input  rd_cdt_pop
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_pd,
        output rd_req_ready,
        output rd_cdt_pop
    );
endinterface

// File: rtl/sdp_rdma_layer_ctrl.sv
// Layer-level read-DMA controller for the SDP element-wise read path.
// Walks a surface/line address pattern, issues one request per line to the
// memory interface chosen by ram_type, gates issue with a latency-FIFO credit
// counter, counts returned atoms and pulses done when the layer has drained.
//
// Optional feature: define NVDLA_SDP_RDMA_ERR_EN to add dp2reg_rdma_err, a
// sticky flag for stray credit pops (pop while idle, or more atoms returned
// than requested). It clears on op_load or reset.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst   clock, synchronous active-high reset
//   reg2dp_*                          layer configuration (static per layer)
//   rd_if (master)                    request valid/ready/pd and credit pop
//   dp2reg_done                       one-cycle layer done pulse
//   dp2reg_rdma_stall                 saturating stall cycle counter
//   dp2reg_rdma_err                   sticky error flag (optional)
module sdp_rdma_layer_ctrl #(
    parameter int unsigned AW        = 64,
    parameter int unsigned NUM_IF    = 2,
    parameter int unsigned LAT_DEPTH = 256,
    parameter int unsigned SZ_W      = 15,
    parameter int unsigned DIM_W     = 13,
    parameter int unsigned STALL_W   = 32
) (
    input  logic                                         nvdla_core_clk,
    input  logic                                         nvdla_core_rst,
    input  logic                                         reg2dp_op_en,
    input  logic [((NUM_IF > 1) ? $clog2(NUM_IF) : 1)-1:0] reg2dp_ram_type,
    input  logic [AW-1:0]                                reg2dp_base_addr,
    input  logic [AW-1:0]                                reg2dp_line_stride,
    input  logic [AW-1:0]                                reg2dp_surface_stride,
    input  logic [SZ_W-1:0]                              reg2dp_line_size,
    input  logic [DIM_W-1:0]                             reg2dp_height,
    input  logic [DIM_W-1:0]                             reg2dp_surf_num,
    input  logic                                         reg2dp_perf_dma_en,
    sdp_rdma_layer_ctrl_if.master                        rd_if,
    output logic                                         dp2reg_done,
`ifdef NVDLA_SDP_RDMA_ERR_EN
    output logic                                         dp2reg_rdma_err,
`endif
    output logic [STALL_W-1:0]                           dp2reg_rdma_stall
);

    localparam int unsigned SELW = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
    localparam int unsigned CW   = $clog2(LAT_DEPTH + 1);
    // Wide enough for both the credit count and size+1, plus a carry bit.
    localparam int unsigned XW   = ((CW > SZ_W + 1) ? CW : SZ_W + 1) + 1;
    // Total atoms of a layer: (size+1) * (height+1) * (surf_num+1).
    localparam int unsigned EW   = SZ_W + 2 * DIM_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrain,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SELW-1:0]     r_sel;
    logic [SZ_W-1:0]     r_size;
    logic [AW-1:0]       r_line_addr;
    logic [AW-1:0]       r_surf_addr;
    logic [DIM_W-1:0]    r_line_idx;
    logic [DIM_W-1:0]    r_surf_idx;
    logic [CW-1:0]       r_credits;
    logic [EW-1:0]       r_expected;
    logic [EW-1:0]       r_returned;
    logic [STALL_W-1:0]  r_stall;

    logic                w_op_load;
    logic [XW-1:0]       w_atoms;
    logic                w_has_cdt;
    logic [NUM_IF-1:0]   w_valid;
    logic                w_ready_sel;
    logic                w_accept;
    logic                w_last_line;
    logic                w_last_surf;
    logic                w_busy;
    logic                w_pop_cnt;
    logic [EW-1:0]       w_ret_nxt;
    logic [XW-1:0]       w_cdt_sum;
    logic [CW-1:0]       w_cdt_nxt;

    assign w_op_load   = reg2dp_op_en && (r_state == StIdle);
    assign w_atoms     = XW'(r_size) + XW'(1);
    assign w_has_cdt   = XW'(r_credits) >= w_atoms;
    assign w_accept    = |(w_valid & rd_if.rd_req_ready);
    assign w_last_line = (r_line_idx == reg2dp_height);
    assign w_last_surf = (r_surf_idx == reg2dp_surf_num);
    assign w_busy      = (r_state == StReq) || (r_state == StDrain);
    // Pops beyond the requested atom count are not counted.
    assign w_pop_cnt   = rd_if.rd_cdt_pop && w_busy && (r_returned < r_expected);
    assign w_ret_nxt   = r_returned + EW'(w_pop_cnt);

    // Valid is raised only on the selected interface, and only with credit.
    always_comb begin
        w_valid     = '0;
        w_ready_sel = 1'b0;
        for (int i = 0; i < NUM_IF; i++) begin
            if (r_sel == SELW'(i)) begin
                w_ready_sel = rd_if.rd_req_ready[i];
                w_valid[i]  = (r_state == StReq) && w_has_cdt;
            end
        end
    end

    // Credit update; accept only happens with credits >= size+1, so the
    // subtraction cannot wrap. Pops at full depth are dropped by the clamp.
    always_comb begin
        w_cdt_sum = XW'(r_credits);
        if (w_accept) begin
            w_cdt_sum = w_cdt_sum - w_atoms;
        end
        if (rd_if.rd_cdt_pop) begin
            w_cdt_sum = w_cdt_sum + XW'(1);
        end
        if (w_cdt_sum > XW'(LAT_DEPTH)) begin
            w_cdt_nxt = CW'(LAT_DEPTH);
        end else begin
            w_cdt_nxt = CW'(w_cdt_sum);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_op_load) begin
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                if (w_accept && w_last_line && w_last_surf) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                // Includes the cycle in which the final atom is popped.
                if (w_ret_nxt == r_expected) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state     <= StIdle;
            r_sel       <= '0;
            r_size      <= '0;
            r_line_addr <= '0;
            r_surf_addr <= '0;
            r_line_idx  <= '0;
            r_surf_idx  <= '0;
            r_credits   <= CW'(LAT_DEPTH);
            r_expected  <= '0;
            r_returned  <= '0;
            r_stall     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_credits <= w_cdt_nxt;
            if (w_op_load) begin
                r_sel       <= reg2dp_ram_type;
                r_size      <= reg2dp_line_size;
                r_line_addr <= reg2dp_base_addr;
                r_surf_addr <= reg2dp_base_addr;
                r_line_idx  <= '0;
                r_surf_idx  <= '0;
                r_expected  <= '0;
                r_returned  <= '0;
                r_stall     <= '0;
            end else begin
                if (w_accept) begin
                    r_expected <= r_expected + EW'(r_size) + EW'(1);
                    if (w_last_line) begin
                        r_surf_addr <= r_surf_addr + reg2dp_surface_stride;
                        r_line_addr <= r_surf_addr + reg2dp_surface_stride;
                        r_line_idx  <= '0;
                        r_surf_idx  <= r_surf_idx + DIM_W'(1);
                    end else begin
                        r_line_addr <= r_line_addr + reg2dp_line_stride;
                        r_line_idx  <= r_line_idx + DIM_W'(1);
                    end
                end
                r_returned <= w_ret_nxt;
                // Stall = request ready to go but the interface refuses it.
                if (reg2dp_perf_dma_en && (r_state == StReq) && !w_ready_sel &&
                    w_has_cdt && !(&r_stall)) begin
                    r_stall <= r_stall + STALL_W'(1);
                end
            end
        end
    end

`ifdef NVDLA_SDP_RDMA_ERR_EN
    logic r_err;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_err <= 1'b0;
        end else if (w_op_load) begin
            r_err <= 1'b0;
        end else if (rd_if.rd_cdt_pop && !w_pop_cnt) begin
            r_err <= 1'b1;
        end
    end

    assign dp2reg_rdma_err = r_err;
`endif

    assign rd_if.rd_req_valid = w_valid;
    assign rd_if.rd_req_pd    = {r_size, r_line_addr};
    assign dp2reg_done        = (r_state == StDone);
    assign dp2reg_rdma_stall  = r_stall;

endmodule
